ahb_lite_arbiter_2m: RTL and testbench

- Two-master AHB-Lite arbiter for the mipsfpga_sys bus.
- M0 is the MIPS core; M1 is a secondary master, such as a boot loader or DMA engine.
- Shares the single system AHB-Lite slave path (memory plus GPIO/scratch decode) between the two masters.
- A per-master input stage captures address phases that lose arbitration. Neither master sees protocol violations: it is stalled through HREADY.

---
 rtl/ahb_lite_arbiter_2m.sv | 150 +++++++++++++++
 tb/tb_ahb_lite_arbiter_2m.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: idle-bus requests forward combinationally; a losing address phase is
// captured and issued no earlier than 1 cycle later; losers are stalled through their HREADY until served.
module ahb_lite_arbiter_2m #(
  parameter int RR_ENABLE = 1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              SI_ClkIn,
  input  logic              SI_Reset,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic              M0_HMASTLOCK,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic [DATA_W-1:0] M0_HRDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic              M1_HMASTLOCK,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [1:0]        GRANT,
  output logic [1:0]        DOWNER
);

  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic              hmastlock;
  } aph_t;

  localparam logic [1:0] TR_BUSY = 2'd1;
  localparam logic [1:0] TR_SEQ  = 2'd3;

  aph_t       live   [2];
  aph_t       pend_q [2];
  aph_t       src    [2];
  aph_t       bus;
  logic [1:0] pend_vld;
  logic [1:0] m_rdy;
  logic [1:0] live_vld;
  logic [1:0] req;
  logic [1:0] hold;
  logic [1:0] grant_q;
  logic [1:0] downer_q;
  logic [1:0] own;
  logic       last_q;  // index of the master that owned the bus most recently

  assign live[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HMASTLOCK};
  assign live[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HMASTLOCK};

  // Data-phase owner sees the slave; anyone else is stalled only while a capture is outstanding.
  assign m_rdy[0] = downer_q[0] ? HREADY : ~pend_vld[0];
  assign m_rdy[1] = downer_q[1] ? HREADY : ~pend_vld[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src[i]      = pend_vld[i] ? pend_q[i] : live[i];
      live_vld[i] = live[i].htrans[1] & m_rdy[i] & ~pend_vld[i];
      req[i]      = pend_vld[i] | live_vld[i];
      hold[i]     = grant_q[i] & ((src[i].htrans == TR_SEQ) || (src[i].htrans == TR_BUSY) ||
                                  src[i].hmastlock);
    end
  end

  always_comb begin
    own = 2'b00;
    if (SI_Reset) begin
      own = 2'b00;
    end else if (!HREADY || (|hold)) begin
      own = grant_q;
    end else if (req == 2'b11) begin
      own = ((RR_ENABLE != 0) && !last_q) ? 2'b10 : 2'b01;
    end else begin
      own = req;
    end
  end

  always_comb begin
    bus = '0;
    if (own[1]) bus = src[1];
    else if (own[0]) bus = src[0];
  end

  assign HADDR     = bus.haddr;
  assign HTRANS    = bus.htrans;
  assign HWRITE    = bus.hwrite;
  assign HSIZE     = bus.hsize;
  assign HBURST    = bus.hburst;
  assign HMASTLOCK = bus.hmastlock;
  assign HWDATA    = downer_q[1] ? M1_HWDATA : (downer_q[0] ? M0_HWDATA : '0);
  assign GRANT     = grant_q;
  assign DOWNER    = downer_q;

  assign M0_HREADY = m_rdy[0];
  assign M1_HREADY = m_rdy[1];
  assign M0_HRESP  = downer_q[0] & HRESP;
  assign M1_HRESP  = downer_q[1] & HRESP;
  assign M0_HRDATA = downer_q[0] ? HRDATA : '0;
  assign M1_HRDATA = downer_q[1] ? HRDATA : '0;

  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      grant_q   <= 2'b00;
      downer_q  <= 2'b00;
      last_q    <= 1'b1;
      pend_vld  <= 2'b00;
      pend_q[0] <= '0;
      pend_q[1] <= '0;
    end else begin
      if (HREADY) begin
        grant_q  <= own;
        downer_q <= bus.htrans[1] ? own : 2'b00;
        if (own[0]) last_q <= 1'b0;
        else if (own[1]) last_q <= 1'b1;
      end
      // A master that saw HREADY=1 believes its address was taken, so capture it even in wait states.
      for (int i = 0; i < 2; i++) begin
        if (live_vld[i] && !(own[i] && HREADY)) begin
          pend_vld[i] <= 1'b1;
          pend_q[i]   <= live[i];
        end else if (pend_vld[i] && own[i] && HREADY) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench for the two-master AHB-Lite arbiter.
module tb_ahb_lite_arbiter_2m;

  logic        SI_ClkIn = 1'b0;
  logic        SI_Reset;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, GRANT, DOWNER;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 SI_ClkIn = ~SI_ClkIn;

  ahb_lite_arbiter_2m #(.RR_ENABLE(1), .ADDR_W(32), .DATA_W(32)) dut (
    .SI_ClkIn(SI_ClkIn), .SI_Reset(SI_Reset),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .GRANT(GRANT), .DOWNER(DOWNER)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m0(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] b);
    M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = w; M0_HBURST = b;
  endtask

  task automatic m1(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] b);
    M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = w; M1_HBURST = b;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge SI_ClkIn);
    #1;
  endtask

  initial begin
    SI_Reset = 1'b1;
    m0(2'd0, 32'h0, 1'b0, 3'd0); m1(2'd0, 32'h0, 1'b0, 3'd0);
    M0_HSIZE = 3'd2; M1_HSIZE = 3'd2; M0_HMASTLOCK = 1'b0; M1_HMASTLOCK = 1'b0;
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    #12;
    chk("rst_grant", GRANT, 2'b00);
    chk("rst_downer", DOWNER, 2'b00);
    chk("rst_htrans", HTRANS, 2'd0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_m0_hready", M0_HREADY, 1'b1);
    chk("rst_m1_hready", M1_HREADY, 1'b1);
    chk("rst_m0_hresp", M0_HRESP, 1'b0);
    chk("rst_m0_hrdata", M0_HRDATA, 32'h0);
    step();
    SI_Reset = 1'b0;

    // 1: single master on an idle bus goes straight through
    m0(2'd2, 32'h1FC00000, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t1_haddr", HADDR, 32'h1FC00000);
    chk("t1_htrans", HTRANS, 2'd2);
    step();
    m0(2'd0, 32'h0, 1'b0, 3'd0); HRDATA = 32'h12345678;
    @(negedge SI_ClkIn);
    chk("t1_grant", GRANT, 2'b01);
    chk("t1_downer", DOWNER, 2'b01);
    chk("t1_m0_hrdata", M0_HRDATA, 32'h12345678);
    chk("t1_m1_hready", M1_HREADY, 1'b1);
    chk("t1_m1_hrdata", M1_HRDATA, 32'h0);
    step();
    HRDATA = 32'h0;
    SI_Reset = 1'b1; #1; SI_Reset = 1'b0;

    // 2: simultaneous NONSEQ, M0 wins after reset, M1 captured then issued
    m0(2'd2, 32'h100, 1'b0, 3'd0); m1(2'd2, 32'h200, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t2_haddr_m0", HADDR, 32'h100);
    chk("t2_m1_hready_pre", M1_HREADY, 1'b1);
    step();
    m0(2'd0, 32'h0, 1'b0, 3'd0); m1(2'd0, 32'h0, 1'b0, 3'd0); HRDATA = 32'hAAAA0001;
    @(negedge SI_ClkIn);
    chk("t2_haddr_m1", HADDR, 32'h200);
    chk("t2_htrans_m1", HTRANS, 2'd2);
    chk("t2_m1_hready_stall", M1_HREADY, 1'b0);
    chk("t2_m0_hrdata", M0_HRDATA, 32'hAAAA0001);
    chk("t2_grant_m0", GRANT, 2'b01);
    step();
    HRDATA = 32'hBBBB0002;
    @(negedge SI_ClkIn);
    chk("t2_m1_hready_done", M1_HREADY, 1'b1);
    chk("t2_downer_m1", DOWNER, 2'b10);
    chk("t2_m1_hrdata", M1_HRDATA, 32'hBBBB0002);
    chk("t2_grant_m1", GRANT, 2'b10);
    step();
    HRDATA = 32'h0;

    // 3: INCR4 burst from M0 is not split by an M1 request at beat 2
    m0(2'd2, 32'h1000, 1'b0, 3'd3);
    @(negedge SI_ClkIn);
    chk("t3_beat1", HADDR, 32'h1000);
    step();
    m0(2'd3, 32'h1004, 1'b0, 3'd3); m1(2'd2, 32'h2000, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t3_beat2", HADDR, 32'h1004);
    chk("t3_grant_b2", GRANT, 2'b01);
    step();
    m0(2'd3, 32'h1008, 1'b0, 3'd3); m1(2'd0, 32'h0, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t3_beat3", HADDR, 32'h1008);
    chk("t3_m1_stall", M1_HREADY, 1'b0);
    step();
    m0(2'd3, 32'h100C, 1'b0, 3'd3);
    @(negedge SI_ClkIn);
    chk("t3_beat4", HADDR, 32'h100C);
    chk("t3_grant_b4", GRANT, 2'b01);
    step();
    m0(2'd0, 32'h0, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t3_m1_haddr", HADDR, 32'h2000);
    chk("t3_m1_htrans", HTRANS, 2'd2);
    chk("t3_grant_last", GRANT, 2'b01);
    step();
    @(negedge SI_ClkIn);
    chk("t3_grant_m1", GRANT, 2'b10);
    chk("t3_m1_ready", M1_HREADY, 1'b1);
    step();

    // 4: wait states during M1 write freeze ownership; M0 captured meanwhile
    m1(2'd2, 32'h300, 1'b1, 3'd0);
    @(negedge SI_ClkIn);
    chk("t4_haddr", HADDR, 32'h300);
    chk("t4_hwrite", HWRITE, 1'b1);
    step();
    m1(2'd0, 32'h0, 1'b0, 3'd0); M1_HWDATA = 32'hDEADBEEF; HREADY = 1'b0;
    m0(2'd2, 32'h400, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t4_hwdata_w1", HWDATA, 32'hDEADBEEF);
    chk("t4_m1_stall", M1_HREADY, 1'b0);
    chk("t4_htrans_w1", HTRANS, 2'd0);
    chk("t4_m0_ready_w1", M0_HREADY, 1'b1);
    step();
    m0(2'd0, 32'h0, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t4_m0_stall", M0_HREADY, 1'b0);
    chk("t4_htrans_w2", HTRANS, 2'd0);
    chk("t4_grant_w2", GRANT, 2'b10);
    chk("t4_downer_w2", DOWNER, 2'b10);
    chk("t4_hwdata_w2", HWDATA, 32'hDEADBEEF);
    step();
    HREADY = 1'b1;
    @(negedge SI_ClkIn);
    chk("t4_m0_haddr", HADDR, 32'h400);
    chk("t4_m0_htrans", HTRANS, 2'd2);
    chk("t4_m1_done", M1_HREADY, 1'b1);
    step();
    M1_HWDATA = 32'h0; HRDATA = 32'hC0FFEE00;
    @(negedge SI_ClkIn);
    chk("t4_m0_downer", DOWNER, 2'b01);
    chk("t4_m0_hrdata", M0_HRDATA, 32'hC0FFEE00);
    chk("t4_m0_ready", M0_HREADY, 1'b1);
    step();
    HRDATA = 32'h0;

    // 5: two-cycle ERROR reaches only the data-phase owner
    m1(2'd2, 32'h500, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t5_haddr", HADDR, 32'h500);
    step();
    m1(2'd0, 32'h0, 1'b0, 3'd0); HRESP = 1'b1; HREADY = 1'b0;
    @(negedge SI_ClkIn);
    chk("t5_m1_hresp_c1", M1_HRESP, 1'b1);
    chk("t5_m1_hready_c1", M1_HREADY, 1'b0);
    chk("t5_m0_hresp_c1", M0_HRESP, 1'b0);
    step();
    HREADY = 1'b1;
    @(negedge SI_ClkIn);
    chk("t5_m1_hresp_c2", M1_HRESP, 1'b1);
    chk("t5_m1_hready_c2", M1_HREADY, 1'b1);
    chk("t5_m0_hresp_c2", M0_HRESP, 1'b0);
    step();
    HRESP = 1'b0;
    @(negedge SI_ClkIn);
    chk("t5_grant_lost", GRANT, 2'b00);
    chk("t5_downer_none", DOWNER, 2'b00);
    step();

    // 6: async reset during a wait state with M1 captured
    m0(2'd2, 32'h700, 1'b0, 3'd0);
    step();
    m0(2'd0, 32'h0, 1'b0, 3'd0); HREADY = 1'b0; m1(2'd2, 32'h600, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t6_m1_ready_pre", M1_HREADY, 1'b1);
    step();
    m1(2'd0, 32'h0, 1'b0, 3'd0);
    #1;
    chk("t6_m1_pend_stall", M1_HREADY, 1'b0);
    SI_Reset = 1'b1;
    #1;
    chk("t6_grant", GRANT, 2'b00);
    chk("t6_downer", DOWNER, 2'b00);
    chk("t6_htrans", HTRANS, 2'd0);
    chk("t6_m0_hready", M0_HREADY, 1'b1);
    chk("t6_m1_hready", M1_HREADY, 1'b1);
    step();
    SI_Reset = 1'b0; HREADY = 1'b1;
    @(negedge SI_ClkIn);
    chk("t6_idle_c1", HTRANS, 2'd0);
    step();
    @(negedge SI_ClkIn);
    chk("t6_idle_c2", HTRANS, 2'd0);
    chk("t6_grant_c2", GRANT, 2'b00);
    chk("t6_downer_c2", DOWNER, 2'b00);
    step();
    m1(2'd2, 32'h800, 1'b0, 3'd0);
    @(negedge SI_ClkIn);
    chk("t6_new_haddr", HADDR, 32'h800);
    chk("t6_new_htrans", HTRANS, 2'd2);
    step();
    m1(2'd0, 32'h0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
